// File: rtl/sdram_cmd_scheduler.sv
// Two-port SDRAM command scheduler: round-robin arbitration, one access in flight,
// open-page row tracking per bank, and registered DRAM command pins.
module sdram_cmd_scheduler #(
    parameter int T_RP  = 2,
    parameter int T_RCD = 2,
    parameter int T_CL  = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [31:0] req0_addr,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [31:0] req1_addr,
    output logic        chip_select,
    output logic        ras,
    output logic        cas,
    output logic        we,
    output logic [2:0]  dram_bank,
    output logic [15:0] dram_addr,
    output logic        resp_valid,
    output logic        resp_id
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRE      = 3'd1;
    localparam logic [2:0] S_WAIT_RP  = 3'd2;
    localparam logic [2:0] S_ACT      = 3'd3;
    localparam logic [2:0] S_WAIT_RCD = 3'd4;
    localparam logic [2:0] S_RW       = 3'd5;
    localparam logic [2:0] S_WAIT_CL  = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    // A wait state lasts T-1 cycles, so counters load T-2 and exit on zero.
    localparam int RP_WAIT  = (T_RP  > 1) ? T_RP  - 2 : 0;
    localparam int RCD_WAIT = (T_RCD > 1) ? T_RCD - 2 : 0;
    localparam int CL_WAIT  = (T_CL  > 1) ? T_CL  - 2 : 0;
    localparam logic [3:0] RP_LOAD  = 4'(RP_WAIT);
    localparam logic [3:0] RCD_LOAD = 4'(RCD_WAIT);
    localparam logic [3:0] CL_LOAD  = 4'(CL_WAIT);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  open_q, open_d;
    logic [15:0] row_q [8];
    logic [15:0] row_d [8];
    logic [31:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic        id_q, id_d;
    logic        cs_q, cs_d, ras_q, ras_d, cas_q, cas_d, we_q, we_d;
    logic [2:0]  bank_q, bank_d;
    logic [15:0] daddr_q, daddr_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q, resp_id_d;

    logic        grant, accept, in_idle, cur_wr;
    logic [31:0] cur_addr;
    logic [2:0]  cur_bank;
    logic [15:0] cur_row;
    logic [9:0]  cur_col;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{req0_addr[2:0], req1_addr[2:0], addr_q[2:0]};

    always_comb begin
        in_idle    = (state_q == S_IDLE);
        grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        accept     = !sys_rst && in_idle && (req0_valid || req1_valid);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        // In IDLE the access is decoded straight from the port being accepted.
        cur_addr   = in_idle ? (grant ? req1_addr : req0_addr) : addr_q;
        cur_wr     = in_idle ? (grant ? req1_we : req0_we) : wr_q;
        cur_bank   = cur_addr[5:3];
        cur_row    = cur_addr[31:16];
        cur_col    = cur_addr[15:6];

        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        id_d         = id_q;
        open_d       = open_q;
        row_d        = row_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d       = cur_addr;
                    wr_d         = cur_wr;
                    id_d         = grant;
                    last_grant_d = grant;
                    if (open_q[cur_bank] && row_q[cur_bank] == cur_row) state_d = S_RW;
                    else if (open_q[cur_bank])                          state_d = S_PRE;
                    else                                                state_d = S_ACT;
                end
            end
            S_PRE: begin
                if (T_RP > 1) begin
                    state_d = S_WAIT_RP;
                    cnt_d   = RP_LOAD;
                end else begin
                    state_d = S_ACT;
                end
            end
            S_WAIT_RP: begin
                if (cnt_q == 4'd0) state_d = S_ACT;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACT: begin
                if (T_RCD > 1) begin
                    state_d = S_WAIT_RCD;
                    cnt_d   = RCD_LOAD;
                end else begin
                    state_d = S_RW;
                end
            end
            S_WAIT_RCD: begin
                if (cnt_q == 4'd0) state_d = S_RW;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RW: begin
                if (T_CL > 1) begin
                    state_d = S_WAIT_CL;
                    cnt_d   = CL_LOAD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WAIT_CL: begin
                if (cnt_q == 4'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_PRE) open_d[cur_bank] = 1'b0;
        if (state_d == S_ACT) begin
            open_d[cur_bank] = 1'b1;
            row_d[cur_bank]  = cur_row;
        end

        // Pins are registered, so they encode the command of the state being entered.
        cs_d    = 1'b0;
        ras_d   = 1'b1;
        cas_d   = 1'b1;
        we_d    = 1'b1;
        bank_d  = 3'd0;
        daddr_d = 16'd0;
        case (state_d)
            S_PRE: begin
                cs_d = 1'b1;
                {we_d, cas_d, ras_d} = 3'b000;
                bank_d = cur_bank;
            end
            S_ACT: begin
                cs_d = 1'b1;
                {we_d, cas_d, ras_d} = 3'b011;
                bank_d  = cur_bank;
                daddr_d = cur_row;
            end
            S_RW: begin
                cs_d = 1'b1;
                {we_d, cas_d, ras_d} = cur_wr ? 3'b001 : 3'b010;
                bank_d  = cur_bank;
                daddr_d = {6'b0, cur_col};
            end
            default: ;
        endcase
        resp_valid_d = (state_d == S_DONE);
        resp_id_d    = (state_d == S_DONE) ? id_q : resp_id_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            open_q       <= 8'd0;
            for (int i = 0; i < 8; i++) row_q[i] <= 16'd0;
            cs_q         <= 1'b0;
            ras_q        <= 1'b1;
            cas_q        <= 1'b1;
            we_q         <= 1'b1;
            bank_q       <= 3'd0;
            daddr_q      <= 16'd0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            open_q       <= open_d;
            row_q        <= row_d;
            cs_q         <= cs_d;
            ras_q        <= ras_d;
            cas_q        <= cas_d;
            we_q         <= we_d;
            bank_q       <= bank_d;
            daddr_q      <= daddr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
        end
    end

    // Captured request fields are only consumed after an accept, so they need no reset.
    always_ff @(posedge sys_clk) begin
        addr_q <= addr_d;
        wr_q   <= wr_d;
        id_q   <= id_d;
    end

    assign chip_select = cs_q;
    assign ras         = ras_q;
    assign cas         = cas_q;
    assign we          = we_q;
    assign dram_bank   = bank_q;
    assign dram_addr   = daddr_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// Bench for sdram_cmd_scheduler: a cycle-level reference model predicts every pin,
// and scenario tasks compare the DUT against it and against hand-derived traces.
`timescale 1ns/1ps
module tb_sdram_cmd_scheduler;
    localparam int T_RP = 2, T_RCD = 2, T_CL = 3;
    localparam logic [26:0] NOP_VEC = {4'b0111, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, v0, v1, we0, we1;
    logic [31:0] a0, a1;
    logic        req0_ready, req1_ready, chip_select, ras, cas, we, resp_valid, resp_id;
    logic [2:0]  dram_bank;
    logic [15:0] dram_addr;

    sdram_cmd_scheduler #(.T_RP(T_RP), .T_RCD(T_RCD), .T_CL(T_CL)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .req0_valid(v0), .req0_ready(req0_ready), .req0_we(we0), .req0_addr(a0),
        .req1_valid(v1), .req1_ready(req1_ready), .req1_we(we1), .req1_addr(a1),
        .chip_select(chip_select), .ras(ras), .cas(cas), .we(we),
        .dram_bank(dram_bank), .dram_addr(dram_addr),
        .resp_valid(resp_valid), .resp_id(resp_id)
    );

    int errors = 0, checks = 0, cyc = 0;
    logic [26:0] obs_vec, exp_vec;
    assign obs_vec = {chip_select, ras, cas, we, dram_bank, dram_addr,
                      resp_valid, resp_valid & resp_id, req0_ready, req1_ready};

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: schedule of the single in-flight access as absolute cycle numbers.
    bit          m_ok = 0, m_last = 1, m_open [8];
    logic [15:0] m_row [8];
    int          idle_at = 0, a_pre = -1, a_act = -1, a_rw = -1, a_resp = -1;
    logic [2:0]  a_bank;
    logic [15:0] a_rowv;
    logic [9:0]  a_col;
    bit          a_we, a_id;

    initial begin
        logic [3:0]  e_cmd;
        logic [2:0]  e_bank;
        logic [15:0] e_addr;
        logic [31:0] ad;
        bit          e_rv, e_id, e_r0, e_r1, g;
        for (int i = 0; i < 8; i++) begin m_open[i] = 0; m_row[i] = 0; end
        exp_vec = NOP_VEC;
        forever begin
            @(negedge clk);
            e_cmd = 4'b0111; e_bank = 3'd0; e_addr = 16'd0;
            if (cyc == a_pre) begin
                e_cmd = 4'b1000; e_bank = a_bank;
            end else if (cyc == a_act) begin
                e_cmd = 4'b1110; e_bank = a_bank; e_addr = a_rowv;
            end else if (cyc == a_rw) begin
                e_cmd = a_we ? 4'b1100 : 4'b1010; e_bank = a_bank; e_addr = {6'b0, a_col};
            end
            e_rv = (cyc == a_resp);
            e_id = a_id;
            e_r0 = 0; e_r1 = 0;
            if (rst) begin
                m_ok = 1; m_last = 1; idle_at = cyc + 1;
                a_pre = -1; a_act = -1; a_rw = -1; a_resp = -1;
                for (int i = 0; i < 8; i++) begin m_open[i] = 0; m_row[i] = 0; end
            end else if (m_ok && cyc >= idle_at && (v0 || v1)) begin
                g = (v0 && v1) ? !m_last : v1;
                m_last = g;
                e_r0 = !g; e_r1 = g;
                ad = g ? a1 : a0;
                a_we = g ? we1 : we0; a_id = g;
                a_bank = ad[5:3]; a_rowv = ad[31:16]; a_col = ad[15:6];
                a_pre = -1; a_act = -1;
                if (m_open[a_bank] && m_row[a_bank] == a_rowv) begin
                    a_rw = cyc + 1;
                end else if (m_open[a_bank]) begin
                    a_pre = cyc + 1; a_act = cyc + 1 + T_RP; a_rw = a_act + T_RCD;
                end else begin
                    a_act = cyc + 1; a_rw = a_act + T_RCD;
                end
                a_resp = a_rw + T_CL;
                idle_at = a_resp + 1;
                m_open[a_bank] = 1; m_row[a_bank] = a_rowv;
            end
            exp_vec = {e_cmd, e_bank, e_addr, e_rv, e_rv & e_id, e_r0, e_r1};
        end
    end

    task automatic issue(input bit port, input bit w, input logic [31:0] addr,
                         output int t, output bit ok);
        @(posedge clk); #1;
        if (port) begin v1 = 1; we1 = w; a1 = addr; end
        else      begin v0 = 1; we0 = w; a0 = addr; end
        ok = 0; t = -1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); #1;
            if ((port ? req1_ready : req0_ready) === 1'b1) begin ok = 1; t = cyc; end
        end
        @(posedge clk); #1;
        v0 = 0; v1 = 0; a0 = $urandom; a1 = $urandom; we0 = 1'($urandom); we1 = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1; v0 = 1; v1 = 1; we0 = 0; we1 = 1; a0 = $urandom; a1 = $urandom;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs_vec !== NOP_VEC)
                $display("FAIL reset_outputs: got %h expected %h", obs_vec, NOP_VEC);
            if (obs_vec !== NOP_VEC) errors++;
        end
        @(posedge clk); #1;
        rst = 0; v0 = 0; v1 = 0;
        @(negedge clk); #1;
        checks++;
        if (obs_vec !== NOP_VEC || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got %h id %b expected %h id 0", obs_vec, resp_id, NOP_VEC);
        end
    endtask

    task automatic test_directed();
        int          offs  [3][3] = '{'{1, 3, 0}, '{1, 0, 0}, '{1, 3, 5}};
        logic [3:0]  cmds  [3][3] = '{'{4'b1110, 4'b1010, 4'b0}, '{4'b1100, 4'b0, 4'b0},
                                      '{4'b1000, 4'b1110, 4'b1010}};
        logic [15:0] dadr  [3][3] = '{'{16'h1, 16'h1, 16'h0}, '{16'h3, 16'h0, 16'h0},
                                      '{16'h0, 16'h2, 16'h1}};
        int          rsp   [3] = '{6, 4, 8};
        bit          ports [3] = '{0, 0, 1};
        bit          wes   [3] = '{0, 1, 0};
        logic [31:0] reqa  [3] = '{32'h0001_0048, 32'h0001_00C8, 32'h0002_0048};
        int t, off;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            issue(ports[k], wes[k], reqa[k], t, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL directed_accept[%0d]: got no ready expected ready", k);
            end
            off = 1;
            while (ok && off <= rsp[k]) begin
                @(negedge clk); #1;
                off = cyc - t;
                checks++;
                if (obs_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL directed_trace[%0d]+%0d: got %h expected %h", k, off, obs_vec, exp_vec);
                end
                for (int j = 0; j < 3; j++) if (offs[k][j] == off) begin
                    checks++;
                    if ({chip_select, ras, cas, we, dram_bank, dram_addr} !== {cmds[k][j], 3'd1, dadr[k][j]}) begin
                        errors++;
                        $display("FAIL directed_cmd[%0d]+%0d: got %b/%0d/%h expected %b/1/%h", k, off,
                                 {chip_select, ras, cas, we}, dram_bank, dram_addr, cmds[k][j], dadr[k][j]);
                    end
                end
                if (off == rsp[k]) begin
                    checks++;
                    if ({resp_valid, resp_id} !== {1'b1, ports[k]}) begin
                        errors++;
                        $display("FAIL directed_resp[%0d]: got v%b id%b expected v1 id%b", k, resp_valid, resp_id, ports[k]);
                    end
                end
                off++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int gcount = 0;
        @(posedge clk); #1;
        rst = 1; v0 = 1; v1 = 1; we0 = 0; we1 = 1; a0 = 32'h0003_0010; a1 = 32'h0004_0028;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 200 && gcount < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL b2b_trace: got %h expected %h", obs_vec, exp_vec);
            end
            if (req0_ready || req1_ready) begin
                checks++;
                if ({req0_ready, req1_ready} !== ((gcount % 2) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL b2b_grant[%0d]: got %b expected %b", gcount,
                             {req0_ready, req1_ready}, (gcount % 2) ? 2'b01 : 2'b10);
                end
                gcount++;
            end
        end
        checks++;
        if (gcount != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d grants expected 4", gcount);
        end
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
    endtask

    task automatic test_reset_abort();
        int t;
        bit ok;
        @(posedge clk); #1; rst = 1; v0 = 0; v1 = 0;
        @(posedge clk); #1; rst = 0;
        issue(0, 0, 32'h0005_0010, t, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_accept: got no ready expected ready"); end
        @(negedge clk); #1;
        checks++;
        if ({chip_select, ras, cas, we, dram_bank, dram_addr} !== {4'b1110, 3'd2, 16'h5}) begin
            errors++;
            $display("FAIL abort_act: got %b/%0d/%h expected 1110/2/0005",
                     {chip_select, ras, cas, we}, dram_bank, dram_addr);
        end
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({chip_select, ras, cas, we, resp_valid} !== 5'b01110 || obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL abort_quiet+%0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        issue(0, 0, 32'h0005_0010, t, ok);
        @(negedge clk); #1;
        checks++;
        if (!ok || {chip_select, ras, cas, we, dram_bank, dram_addr} !== {4'b1110, 3'd2, 16'h5}) begin
            errors++;
            $display("FAIL abort_reopen: got %b/%0d/%h expected 1110/2/0005",
                     {chip_select, ras, cas, we}, dram_bank, dram_addr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 199) == 0);
            v0  = ($urandom_range(0, 9) < 6);
            v1  = ($urandom_range(0, 9) < 6);
            we0 = 1'($urandom); we1 = 1'($urandom);
            a0  = {16'($urandom_range(0, 3)), 10'($urandom), 3'($urandom_range(0, 3)), 3'($urandom)};
            a1  = {16'($urandom_range(0, 3)), 10'($urandom), 3'($urandom_range(0, 3)), 3'($urandom)};
            @(negedge clk); #1;
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random_trace@%0d: got %h expected %h", cyc, obs_vec, exp_vec);
            end
        end
        @(posedge clk); #1;
        rst = 0; v0 = 0; v1 = 0;
    endtask

    initial begin
        rst = 1; v0 = 0; v1 = 0; we0 = 0; we1 = 0; a0 = 0; a1 = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sdram_cmd_scheduler.md
SDRAM_CMD_SCHEDULER -- requirements
Module: sdram_cmd_scheduler

Interface
REQ-001 Parameter T_RP, default 2, PRECHARGE-to-ACTIVATE spacing in cycles (>=1).
REQ-002 Parameter T_RCD, default 2, ACTIVATE-to-READ/WRITE spacing in cycles (>=1).
REQ-003 Parameter T_CL, default 3, READ/WRITE-command-to-response spacing in cycles (>=1).
REQ-004 sys_clk  in  1  sole clock; all state changes on rising edge.
REQ-005 sys_rst  in  1  reset, synchronous, active-high.
REQ-006 req0_valid / req1_valid  in  1 each  requester N has a pending access.
REQ-007 req0_ready / req1_ready  out  1 each  requester N's access accepted this cycle.
REQ-008 req0_we / req1_we  in  1 each  1=write, 0=read.
REQ-009 req0_addr / req1_addr  in  32 each  row=addr[31:16], col=addr[15:6], bank=addr[5:3].
REQ-010 chip_select, ras, cas, we  out  1 each  DRAM command pins, registered.
REQ-011 dram_bank  out  3  bank of current command.
REQ-012 dram_addr  out  16  row on ACTIVATE; {6'b0,col} on READ/WRITE; 0 otherwise.
REQ-013 resp_valid  out  1  one-cycle completion pulse.
REQ-014 resp_id  out  1  requester index of completed access.

Function
REQ-015 Command patterns {we,cas,ras} with chip_select=1: ACTIVATE=3'b011, READ=3'b010, WRITE=3'b001, PRECHARGE=3'b000; NOP = chip_select=0, ras=cas=we=1.
REQ-016 Only one access in flight; all non-command cycles drive NOP.
REQ-017 Open-row table: per bank, open bit plus 16-bit row; rows stay open after access (open-page policy).
REQ-018 States: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RW, WAIT_CL, DONE.
REQ-019 IDLE: reqN_ready combinational, high only in IDLE for the granted port with valid high; request captured on that edge.
REQ-020 Arbitration round-robin: both valid -> grant port not granted last; last-grant reset value = 1 (port 0 wins first tie); single valid -> that port.
REQ-021 From IDLE after accept: bank open and row match -> RW; bank open and row mismatch -> PRE; bank closed -> ACT.
REQ-022 PRE issues PRECHARGE for the bank, clears its open bit; ACTIVATE issued exactly T_RP cycles after PRECHARGE (WAIT_RP counts).
REQ-023 ACT issues ACTIVATE with row, sets open bit and row; READ/WRITE issued exactly T_RCD cycles after ACTIVATE (WAIT_RCD counts).
REQ-024 RW issues READ or WRITE per captured we with col; resp_valid pulses exactly T_CL cycles after that command (DONE state), resp_id = captured port.
REQ-025 DONE -> IDLE next cycle; no request accepted during DONE.
REQ-026 Latency from accept cycle t: hit -> RW t+1, resp t+1+T_CL; closed -> ACT t+1, RW t+1+T_RCD; miss -> PRE t+1, ACT t+1+T_RP, RW t+1+T_RP+T_RCD.
REQ-027 Wait counters sized for parameters up to 15; T=1 means command in the very next cycle (WAIT state skipped).
REQ-028 Request inputs changing after accept have no effect on the in-flight access.

Reset
REQ-029 sys_rst high on an edge: state IDLE, all open bits 0, rows 0, last-grant 1, counters 0, outputs NOP, dram_bank=0, dram_addr=0, resp_valid=0, resp_id=0.
REQ-030 reqN_ready low while sys_rst high.
REQ-031 Reset mid-access aborts it: no further command, no resp_valid for it.

Verification (T_RP=2, T_RCD=2, T_CL=3)
REQ-032 After reset, req0 read 0x0001_0048 accepted cycle t -> ACTIVATE bank1 row 0x0001 at t+1, READ bank1 dram_addr 0x0001 at t+3, resp_valid id0 at t+6.
REQ-033 Then req0 write 0x0001_00C8 at t -> WRITE bank1 dram_addr 0x0003 at t+1 (no ACTIVATE), resp at t+4.
REQ-034 Then req1 read 0x0002_0048 at t -> PRECHARGE bank1 t+1, ACTIVATE row 0x0002 t+3, READ t+5, resp id1 t+8.
REQ-035 req0_valid and req1_valid held high continuously from reset -> grants 0,1,0,1; no ready during non-IDLE cycles.
REQ-036 sys_rst pulsed during WAIT_RCD of bank 2 -> NOP next cycle, no resp_valid; next request to bank 2 same row issues ACTIVATE (not a hit).
